nsctrl_handover: RTL

//  Generates the sequencer-select signal 'change' for the NMR control output mux.

---
 rtl/nsctrl_handover_if.sv | 24 ++
 rtl/nsctrl_handover.sv | 136 +++++++++++++
 2 files changed

// File: rtl/nsctrl_handover_if.sv
// Handover control bundle between the NMR output-mux controller and its environment.
interface nsctrl_handover_if;
  logic req_sel;
  logic busy_s;
  logic busy_n;
  logic err_clr;
  logic change;
  logic en_s;
  logic en_n;
  logic safe_force;
  logic sw_pending;
  logic sw_done;
  logic err;

  modport slave (
    input  req_sel, busy_s, busy_n, err_clr,
    output change, en_s, en_n, safe_force, sw_pending, sw_done, err
  );

  modport master (
    output req_sel, busy_s, busy_n, err_clr,
    input  change, en_s, en_n, safe_force, sw_pending, sw_done, err
  );
endinterface

// File: rtl/nsctrl_handover.sv
// Sequencer-select controller for the NMR output mux: swaps between the s and n
// sequencers only once the active one has drained, with forced-safe guard intervals.
module nsctrl_handover #(
  parameter int unsigned GUARD_CYC   = 16,
  parameter int unsigned TIMEOUT_CYC = 4096,
  parameter int unsigned CNT_W       = 13
) (
  input  logic                 clk_sys,
  input  logic                 rst_n,
  nsctrl_handover_if.slave     hb
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_GUARD1,
    ST_SWAP,
    ST_GUARD2
  } state_t;

  localparam logic [CNT_W-1:0] G_LAST  = CNT_W'(GUARD_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_change;
  logic             r_en_s;
  logic             r_en_n;
  logic             r_safe;
  logic             r_pend;
  logic             r_done;
  logic             r_err;

  logic w_busy_cur;
  logic w_req_mismatch;

  // The non-selected sequencer's busy never influences the controller.
  assign w_busy_cur     = r_change ? hb.busy_n : hb.busy_s;
  assign w_req_mismatch = (hb.req_sel != r_change);

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_change <= 1'b0;
      r_en_s   <= 1'b1;
      r_en_n   <= 1'b0;
      r_safe   <= 1'b0;
      r_pend   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      // Clear first so a timeout in the same cycle (assigned below) wins.
      if (hb.err_clr) r_err <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (w_req_mismatch && !r_err) begin
            r_state <= ST_DRAIN;
            r_en_s  <= 1'b0;
            r_en_n  <= 1'b0;
            r_pend  <= 1'b1;
          end
        end

        ST_DRAIN: begin
          if (!w_req_mismatch) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_en_s  <= !r_change;
            r_en_n  <= r_change;
            r_pend  <= 1'b0;
          end else if (!w_busy_cur) begin
            r_state <= ST_GUARD1;
            r_cnt   <= '0;
            r_safe  <= 1'b1;
          end else if (r_cnt == TO_LAST) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_err   <= 1'b1;
            r_en_s  <= !r_change;
            r_en_n  <= r_change;
            r_pend  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        ST_GUARD1: begin
          if (r_cnt == G_LAST) begin
            r_state <= ST_SWAP;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        ST_SWAP: begin
          r_state  <= ST_GUARD2;
          r_cnt    <= '0;
          r_change <= !r_change;
        end

        ST_GUARD2: begin
          if (r_cnt == G_LAST) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_safe  <= 1'b0;
            r_en_s  <= !r_change;
            r_en_n  <= r_change;
            r_pend  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign hb.change     = r_change;
  assign hb.en_s       = r_en_s;
  assign hb.en_n       = r_en_n;
  assign hb.safe_force = r_safe;
  assign hb.sw_pending = r_pend;
  assign hb.sw_done    = r_done;
  assign hb.err        = r_err;

endmodule
